// File: rtl/arm_mem_pkg.sv
// Shared definitions for the data-memory path: SRAM controller state encoding
// and the default data-memory base address used by the MEM stage.
package arm_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } memState_e;

  localparam logic [31:0] DATA_MEM_BASE_DEFAULT = 32'd1024;
  localparam int unsigned WAIT_CYCLES_DEFAULT   = 1;

endpackage

// File: rtl/sram_controller.sv
// Data-memory responder: services a 32-bit MEM-stage load/store as two 16-bit
// SRAM accesses (low half, then high half) and holds ready low until done.
module sram_controller
  import arm_mem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES   = WAIT_CYCLES_DEFAULT,
  parameter logic [31:0] DATA_MEM_BASE = DATA_MEM_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  output logic        sram_we_n
);

  localparam logic [3:0] LastCount = 4'(WAIT_CYCLES);

  memState_e   state_q;
  logic [3:0]  count_q;
  logic        isWrite_q;
  logic [16:0] word_q;
  logic [31:0] wdata_q;
  logic [31:0] readData_q;
  logic [17:0] sramAddr_q;
  logic [15:0] dqOut_q;
  logic        dqOe_q;
  logic        weN_q;

  logic        request_d;
  logic [31:0] offset_d;
  logic [16:0] word_d;
  logic        lastCount_d;
  logic        unusedOffsetBits;

  // Offset wraps modulo 2^32, so addresses below the base land in high SRAM.
  assign request_d        = wr_en | rd_en;
  assign offset_d         = address - DATA_MEM_BASE;
  assign word_d           = offset_d[18:2];
  assign unusedOffsetBits = ^{offset_d[31:19], offset_d[1:0]};
  assign lastCount_d      = (count_q == LastCount);

  // Bus outputs are set on the edge entering each state so they are glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= 4'd0;
      isWrite_q  <= 1'b0;
      word_q     <= 17'd0;
      wdata_q    <= 32'd0;
      readData_q <= 32'd0;
      sramAddr_q <= 18'd0;
      dqOut_q    <= 16'd0;
      dqOe_q     <= 1'b0;
      weN_q      <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (request_d) begin
            state_q    <= LO;
            count_q    <= 4'd0;
            isWrite_q  <= wr_en;
            word_q     <= word_d;
            wdata_q    <= write_data;
            sramAddr_q <= {word_d, 1'b0};
            dqOut_q    <= write_data[15:0];
            dqOe_q     <= wr_en;
            weN_q      <= ~wr_en;
          end
        end
        LO: begin
          if (lastCount_d) begin
            state_q    <= HI;
            count_q    <= 4'd0;
            sramAddr_q <= {word_q, 1'b1};
            dqOut_q    <= wdata_q[31:16];
            if (!isWrite_q) begin
              readData_q[15:0] <= sram_dq_in;
            end
          end else begin
            count_q <= count_q + 4'd1;
          end
        end
        HI: begin
          if (lastCount_d) begin
            state_q <= DONE;
            count_q <= 4'd0;
            dqOe_q  <= 1'b0;
            weN_q   <= 1'b1;
            if (!isWrite_q) begin
              readData_q[31:16] <= sram_dq_in;
            end
          end else begin
            count_q <= count_q + 4'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ready       = (state_q == DONE) | ((state_q == IDLE) & ~request_d);
  assign read_data   = readData_q;
  assign sram_addr   = sramAddr_q;
  assign sram_dq_out = dqOut_q;
  assign sram_dq_oe  = dqOe_q;
  assign sram_we_n   = weN_q;

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench for sram_controller with behavioural 256Kx16 SRAM models;
// one W=1 instance for the main traffic plus W=0 and W=3 instances for timing.
module tb_sram_controller;
  import arm_mem_pkg::*;

  typedef struct {
    logic [31:0] expData;
    int          expLow;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        wrEn, rdEn;
  logic [31:0] address, writeData, readData;
  logic        ready;
  logic [17:0] sramAddr;
  logic [15:0] sramDqOut, sramDqIn;
  logic        sramDqOe, sramWeN;
  logic [15:0] sram [262144];

  logic        auxWr [2];
  logic        auxRd [2];
  logic [31:0] auxAddr [2];
  logic [31:0] auxWdata [2];
  logic [31:0] auxRdata [2];
  logic        auxReady [2];
  logic [17:0] auxSaddr [2];
  logic [15:0] auxDqOut [2];
  logic [15:0] auxDqIn [2];
  logic        auxOe [2];
  logic        auxWeN [2];
  logic [15:0] auxMem [2][262144];

  exp_t        sbQ [$];
  exp_t        monItem;
  logic [31:0] modelReadData;
  int          errors = 0;
  int          checks = 0;
  int          lowCount = 0;

  always #5 clk = ~clk;

  sram_controller #(.WAIT_CYCLES(1), .DATA_MEM_BASE(32'd1024)) dut (
    .clk(clk), .rst(rst), .wr_en(wrEn), .rd_en(rdEn), .address(address),
    .write_data(writeData), .read_data(readData), .ready(ready),
    .sram_addr(sramAddr), .sram_dq_out(sramDqOut), .sram_dq_oe(sramDqOe),
    .sram_dq_in(sramDqIn), .sram_we_n(sramWeN)
  );

  sram_controller #(.WAIT_CYCLES(0), .DATA_MEM_BASE(32'd1024)) dutW0 (
    .clk(clk), .rst(rst), .wr_en(auxWr[0]), .rd_en(auxRd[0]), .address(auxAddr[0]),
    .write_data(auxWdata[0]), .read_data(auxRdata[0]), .ready(auxReady[0]),
    .sram_addr(auxSaddr[0]), .sram_dq_out(auxDqOut[0]), .sram_dq_oe(auxOe[0]),
    .sram_dq_in(auxDqIn[0]), .sram_we_n(auxWeN[0])
  );

  sram_controller #(.WAIT_CYCLES(3), .DATA_MEM_BASE(32'd1024)) dutW3 (
    .clk(clk), .rst(rst), .wr_en(auxWr[1]), .rd_en(auxRd[1]), .address(auxAddr[1]),
    .write_data(auxWdata[1]), .read_data(auxRdata[1]), .ready(auxReady[1]),
    .sram_addr(auxSaddr[1]), .sram_dq_out(auxDqOut[1]), .sram_dq_oe(auxOe[1]),
    .sram_dq_in(auxDqIn[1]), .sram_we_n(auxWeN[1])
  );

  // Synchronous-write, asynchronous-read SRAM models.
  always @(posedge clk) begin
    if (!sramWeN) sram[sramAddr] <= sramDqOut;
    if (!auxWeN[0]) auxMem[0][auxSaddr[0]] <= auxDqOut[0];
    if (!auxWeN[1]) auxMem[1][auxSaddr[1]] <= auxDqOut[1];
  end

  assign sramDqIn  = sram[sramAddr];
  assign auxDqIn[0] = auxMem[0][auxSaddr[0]];
  assign auxDqIn[1] = auxMem[1][auxSaddr[1]];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic waitReady(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (ready) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: ready never rose within 40 cycles", name);
    end
    @(posedge clk);
    #1;
  endtask

  // Expected response is queued before the request is driven.
  task automatic applyStimulus(input logic wr, input logic rd, input logic [31:0] addr,
                               input logic [31:0] data, input logic [31:0] expRead,
                               input string name);
    exp_t e;
    if (rd && !wr) modelReadData = expRead;
    e.expData = modelReadData;
    e.expLow  = 5;
    e.name    = name;
    sbQ.push_back(e);
    wrEn      = wr;
    rdEn      = rd;
    address   = addr;
    writeData = data;
    waitReady(name);
  endtask

  task automatic releaseBus();
    wrEn = 1'b0;
    rdEn = 1'b0;
  endtask

  task automatic runAux(input int k, input int w, input string name);
    int  lowCnt = 0;
    bit  done = 1'b0;
    auxRd[k]   = 1'b1;
    auxAddr[k] = 32'd1028;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      if (auxReady[k]) begin
        done = 1'b1;
      end else begin
        lowCnt++;
        if (cyc == 1) checkOutput({name, " sram_addr LO"}, 32'(auxSaddr[k]), 32'd2);
        if (cyc == w + 2) checkOutput({name, " sram_addr HI"}, 32'(auxSaddr[k]), 32'd3);
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: ready never rose within 40 cycles", name);
    end
    checkOutput({name, " ready-low cycles"}, 32'(lowCnt), 32'(2 * w + 3));
    checkOutput({name, " read_data"}, auxRdata[k], 32'h7E81_3C3C);
    @(posedge clk);
    #1;
    auxRd[k] = 1'b0;
  endtask

  // Monitor: a request seen with ready high is a completed access (DONE).
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        lowCount = 0;
      end else if (wrEn || rdEn) begin
        if (!ready) begin
          lowCount++;
        end else begin
          if (sbQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected completion: read_data 0x%08h with empty scoreboard", readData);
          end else begin
            monItem = sbQ.pop_front();
            checkOutput({monItem.name, " read_data"}, readData, monItem.expData);
            checkOutput({monItem.name, " ready-low cycles"}, 32'(lowCount), 32'(monItem.expLow));
            checkOutput({monItem.name, " dq_oe in DONE"}, 32'(sramDqOe), 32'd0);
            checkOutput({monItem.name, " we_n in DONE"}, 32'(sramWeN), 32'd1);
          end
          lowCount = 0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0;
    modelReadData = 32'd0;
    releaseBus();
    address = 32'd0;
    writeData = 32'd0;
    for (int k = 0; k < 2; k++) begin
      auxWr[k] = 1'b0;
      auxRd[k] = 1'b0;
      auxAddr[k] = 32'd0;
      auxWdata[k] = 32'd0;
    end
    for (int i = 0; i < 262144; i++) begin
      sram[i] = 16'h0000;
      auxMem[0][i] = 16'h0000;
      auxMem[1][i] = 16'h0000;
    end
    sram[9] = 16'hCAFE;
    for (int k = 0; k < 2; k++) begin
      auxMem[k][2] = 16'h3C3C;
      auxMem[k][3] = 16'h7E81;
    end

    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset read_data", readData, 32'd0);
    checkOutput("reset sram_addr", 32'(sramAddr), 32'd0);
    checkOutput("reset sram_dq_out", 32'(sramDqOut), 32'd0);
    checkOutput("reset sram_dq_oe", 32'(sramDqOe), 32'd0);
    checkOutput("reset sram_we_n", 32'(sramWeN), 32'd1);
    checkOutput("reset ready", 32'(ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] idle for 20 cycles");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("idle ready/we_n/oe", 32'({ready, sramWeN, sramDqOe}), 32'b110);
    end
    @(posedge clk);
    #1;

    $display("[TB] reset during HI of a write");
    begin
      exp_t e;
      bit   inHi = 1'b0;
      e.expData = modelReadData;
      e.expLow  = 5;
      e.name    = "restarted wr 1040";
      sbQ.push_back(e);
      wrEn = 1'b1;
      address = 32'd1040;
      writeData = 32'h1111_2222;
      for (int i = 0; i < 20 && !inHi; i++) begin
        @(negedge clk);
        if (sramAddr == 18'd9) inHi = 1'b1;
      end
      if (!inHi) begin
        checks++;
        errors++;
        $display("[TB] FAIL reach HI: sram_addr never became 9 within 20 cycles");
      end
      #1 rst = 1'b1;
      #1;
      checkOutput("async reset sram_addr", 32'(sramAddr), 32'd0);
      checkOutput("async reset sram_dq_out", 32'(sramDqOut), 32'd0);
      checkOutput("async reset sram_dq_oe", 32'(sramDqOe), 32'd0);
      checkOutput("async reset sram_we_n", 32'(sramWeN), 32'd1);
      checkOutput("async reset ready with request held", 32'(ready), 32'd0);
      checkOutput("aborted write low half", 32'(sram[8]), 32'h2222);
      checkOutput("aborted write high half", 32'(sram[9]), 32'hCAFE);
      @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("restart in LO sram_addr", 32'(sramAddr), 32'd8);
      checkOutput("restart in LO we_n/oe", 32'({sramWeN, sramDqOe}), 32'b01);
      waitReady("restarted wr 1040");
      releaseBus();
      checkOutput("restarted write low half", 32'(sram[8]), 32'h2222);
      checkOutput("restarted write high half", 32'(sram[9]), 32'h1111);
    end

    $display("[TB] write then read 1024");
    applyStimulus(1'b1, 1'b0, 32'd1024, 32'hDEAD_BEEF, 32'd0, "wr 1024");
    releaseBus();
    checkOutput("SRAM[0]", 32'(sram[0]), 32'hBEEF);
    checkOutput("SRAM[1]", 32'(sram[1]), 32'hDEAD);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b1, 32'd1024, 32'd0, 32'hDEAD_BEEF, "rd 1024");
    releaseBus();

    $display("[TB] simultaneous wr_en and rd_en");
    applyStimulus(1'b1, 1'b1, 32'd1032, 32'h1234_5678, 32'd0, "wr+rd 1032");
    releaseBus();
    checkOutput("SRAM[4]", 32'(sram[4]), 32'h5678);
    checkOutput("SRAM[5]", 32'(sram[5]), 32'h1234);

    $display("[TB] back-to-back write/read 1036");
    applyStimulus(1'b1, 1'b0, 32'd1036, 32'hA5A5_5A5A, 32'd0, "b2b wr 1036");
    applyStimulus(1'b0, 1'b1, 32'd1036, 32'd0, 32'hA5A5_5A5A, "b2b rd 1036");
    releaseBus();
    checkOutput("SRAM[6]", 32'(sram[6]), 32'h5A5A);
    checkOutput("SRAM[7]", 32'(sram[7]), 32'hA5A5);

    $display("[TB] WAIT_CYCLES 0 and 3");
    runAux(0, 0, "W0 rd 1028");
    runAux(1, 3, "W3 rd 1028");

    repeat (4) @(posedge clk);
    #1;
    checkOutput("scoreboard drained", 32'(sbQ.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
